midi_voice_allocator: RTL and testbench

- Parses the raw MIDI byte stream from the UART/byte receiver into note-on and note-off commands.
- Allocates each note-on to one of NUM_VOICES note-player voices and routes note-offs to the voice holding that note.
- Sits between the byte receiver and the bank of note players inside midi_player, and drives each player's load, release and note/velocity inputs.

---
 rtl/midi_voice_allocator.sv | 198 +++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : midi_voice_allocator
// Purpose  : Parses a raw MIDI byte stream into note-on/note-off commands and
//            assigns them to NUM_VOICES note-player voices. A note-on goes to
//            the voice already holding that note, else to the lowest-index
//            idle voice, else to the oldest voice (steal). A note-off releases
//            the active voice holding that note.
// Ports    : clk            - system clock
//            reset          - asynchronous, active-low reset
//            new_byte_ready - one-cycle strobe, new_byte valid
//            new_byte       - MIDI byte
//            voice_load     - one-hot pulse, voice (re)starts its note
//            voice_release  - one-hot pulse, voice stops its note
//            voice_active   - per-voice note currently held
//            voice_note     - packed notes, voice i at [7i+6:7i]
//            voice_velocity - packed velocities, same layout
//            steal          - pulse with voice_load when an active voice is taken
// Revision : 1.0 - initial release
// ============================================================================
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_byte_ready,
  input  logic [7:0]              new_byte,
  output logic [NUM_VOICES-1:0]   voice_load,
  output logic [NUM_VOICES-1:0]   voice_release,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic                    steal
);

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    IGNORE    = 2'd1,
    DATA1     = 2'd2,
    DATA2     = 2'd3
  } parse_state_t;

  // --------------------------------------------------------------------------
  // Parser
  // --------------------------------------------------------------------------
  parse_state_t state_q;
  logic         kind_on_q;     // running status kind: 1 = 0x9n, 0 = 0x8n
  logic [6:0]   msg_note_q;
  logic         cmd_valid_q;   // a complete message was captured last edge
  logic         cmd_on_q;      // that message is a note-on (0x9n, velocity>0)
  logic [6:0]   cmd_note_q;
  logic [6:0]   cmd_vel_q;

  logic         byte_used;
  assign byte_used = new_byte_ready && (new_byte < 8'hF8);  // realtime bytes vanish

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NO_STATUS;
      kind_on_q   <= 1'b0;
      msg_note_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_on_q    <= 1'b0;
      cmd_note_q  <= '0;
      cmd_vel_q   <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (byte_used) begin
        if (new_byte[7]) begin
          // 0x80-0x9F: note-off/note-on status; anything else drops running status
          if (new_byte[7:5] == 3'b100) begin
            kind_on_q <= new_byte[4];
            state_q   <= DATA1;
          end else begin
            state_q   <= IGNORE;
          end
        end else begin
          case (state_q)
            DATA1: begin
              msg_note_q <= new_byte[6:0];
              state_q    <= DATA2;
            end
            DATA2: begin
              cmd_valid_q <= 1'b1;
              cmd_on_q    <= kind_on_q && (new_byte[6:0] != 7'd0);
              cmd_note_q  <= msg_note_q;
              cmd_vel_q   <= new_byte[6:0];
              state_q     <= DATA1;    // running status: next pair is a new message
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Voice state
  // --------------------------------------------------------------------------
  logic [NUM_VOICES-1:0] load_q;
  logic [NUM_VOICES-1:0] release_q;
  logic [NUM_VOICES-1:0] active_q;
  logic                  steal_q;
  logic [6:0]            vnote_q [NUM_VOICES];
  logic [6:0]            vvel_q  [NUM_VOICES];
  logic [VIDX_W-1:0]     age_q   [NUM_VOICES];

  // Target selection. Loops run from the top index down so the lowest
  // matching index is the one left standing.
  logic              hit_found;
  logic [VIDX_W-1:0] hit_idx;
  logic              free_found;
  logic [VIDX_W-1:0] free_idx;
  logic [VIDX_W-1:0] old_idx;
  logic [VIDX_W-1:0] tgt_idx;
  logic              do_steal;

  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && (vnote_q[i] == cmd_note_q)) begin
        hit_found = 1'b1;
        hit_idx   = VIDX_W'(i);
      end
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(i);
      end
      if (age_q[i] == VIDX_W'(NUM_VOICES - 1)) begin
        old_idx = VIDX_W'(i);
      end
    end
    do_steal = !hit_found && !free_found;
    if (hit_found) begin
      tgt_idx = hit_idx;
    end else if (free_found) begin
      tgt_idx = free_idx;
    end else begin
      tgt_idx = old_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q    <= '0;
      release_q <= '0;
      active_q  <= '0;
      steal_q   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i] <= '0;
        vvel_q[i]  <= '0;
        age_q[i]   <= VIDX_W'(i);
      end
    end else begin
      load_q    <= '0;
      release_q <= '0;
      steal_q   <= 1'b0;
      if (cmd_valid_q) begin
        if (cmd_on_q) begin
          vnote_q[tgt_idx]  <= cmd_note_q;
          vvel_q[tgt_idx]   <= cmd_vel_q;
          active_q[tgt_idx] <= 1'b1;
          load_q[tgt_idx]   <= 1'b1;
          steal_q           <= do_steal;
          // Move the target to rank 0; everything younger shifts up one,
          // keeping the ranks a permutation.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (age_q[i] < age_q[tgt_idx]) begin
              age_q[i] <= age_q[i] + VIDX_W'(1);
            end
          end
          age_q[tgt_idx] <= '0;
        end else if (hit_found) begin
          active_q[hit_idx]  <= 1'b0;
          release_q[hit_idx] <= 1'b1;
        end
      end
    end
  end

  assign voice_load    = load_q;
  assign voice_release = release_q;
  assign voice_active  = active_q;
  assign steal         = steal_q;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
    assign voice_note[7*gi +: 7]     = vnote_q[gi];
    assign voice_velocity[7*gi +: 7] = vvel_q[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_voice_allocator
// Purpose  : Self-checking bench for midi_voice_allocator. A recency-list
//            reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_voice_allocator;

  localparam int NV = 4;
  localparam int OW = 3*NV + 1 + 14*NV;

  logic            clk;
  logic            reset;
  logic            new_byte_ready;
  logic [7:0]      new_byte;
  logic [NV-1:0]   voice_load;
  logic [NV-1:0]   voice_release;
  logic [NV-1:0]   voice_active;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_velocity;
  logic            steal;

  int errors = 0;
  int checks = 0;

  midi_voice_allocator #(.NUM_VOICES(NV), .VIDX_W(2)) dut (
    .clk(clk), .reset(reset),
    .new_byte_ready(new_byte_ready), .new_byte(new_byte),
    .voice_load(voice_load), .voice_release(voice_release),
    .voice_active(voice_active), .voice_note(voice_note),
    .voice_velocity(voice_velocity), .steal(steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OW-1:0] dut_out;
  assign dut_out = {voice_load, voice_release, voice_active, steal, voice_note, voice_velocity};

  // ---------------------------------------------------------------- model
  logic [6:0]    m_note [NV];
  logic [6:0]    m_vel  [NV];
  logic [NV-1:0] m_act;
  logic [NV-1:0] m_load;
  logic [NV-1:0] m_rel;
  logic          m_steal;
  int            rec[$];          // voices, most recently loaded first
  int            m_kind;          // 0 none, 1 note-off, 2 note-on
  bit            m_have_note;
  logic [6:0]    m_pnote;
  bit            p_valid;         // message completed, takes effect next edge
  bit            p_on;
  logic [6:0]    p_note;
  logic [6:0]    p_vel;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = '0;
      m_vel[i]  = '0;
    end
    m_act = '0; m_load = '0; m_rel = '0; m_steal = 1'b0;
    rec = {};
    for (int i = 0; i < NV; i++) rec.push_back(i);
    m_kind = 0; m_have_note = 0; p_valid = 0;
  endfunction

  function automatic void model_apply();
    int v;
    v = -1;
    for (int i = 0; i < NV; i++)
      if (v < 0 && m_act[i] && m_note[i] == p_note) v = i;
    if (!p_on) begin
      if (v >= 0) begin
        m_act[v] = 1'b0;
        m_rel[v] = 1'b1;
      end
      return;
    end
    if (v < 0)
      for (int i = 0; i < NV; i++)
        if (v < 0 && !m_act[i]) v = i;
    if (v < 0) begin
      v = rec[rec.size()-1];
      m_steal = 1'b1;
    end
    m_note[v] = p_note;
    m_vel[v]  = p_vel;
    m_act[v]  = 1'b1;
    m_load[v] = 1'b1;
    for (int k = 0; k < rec.size(); k++)
      if (rec[k] == v) begin
        rec.delete(k);
        break;
      end
    rec.push_front(v);
  endfunction

  function automatic void model_edge(input logic rdy, input logic [7:0] b);
    m_load = '0; m_rel = '0; m_steal = 1'b0;
    if (p_valid) model_apply();
    p_valid = 0;
    if (!rdy || b >= 8'hF8) return;
    if (b >= 8'h80) begin
      if (b >= 8'h80 && b <= 8'h9F) m_kind = (b >= 8'h90) ? 2 : 1;
      else m_kind = 0;
      m_have_note = 0;
    end else if (m_kind != 0) begin
      if (!m_have_note) begin
        m_pnote = b[6:0];
        m_have_note = 1;
      end else begin
        p_valid = 1;
        p_on    = (m_kind == 2) && (b != 8'd0);
        p_note  = m_pnote;
        p_vel   = b[6:0];
        m_have_note = 0;
      end
    end
  endfunction

  function automatic logic [OW-1:0] model_outputs();
    logic [7*NV-1:0] nt, vl;
    for (int i = 0; i < NV; i++) begin
      nt[7*i +: 7] = m_note[i];
      vl[7*i +: 7] = m_vel[i];
    end
    return {m_load, m_rel, m_act, m_steal, nt, vl};
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic rdy, input logic [7:0] b);
    new_byte_ready = rdy;
    new_byte       = b;
    @(posedge clk);
    model_edge(rdy, b);
    @(negedge clk);
    new_byte_ready = 1'b0;
    new_byte       = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    if (dut_out !== {OW{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", dut_out);
    end
    checks++;
    tick(1'b0, 8'h00);
    if (dut_out !== model_outputs()) begin
      errors++;
      $display("FAIL reset_idle: got %h exp %h", dut_out, model_outputs());
    end
    checks++;
  endtask

  task automatic test_single_note();
    logic [7:0] seq[] = '{8'h90, 8'd60, 8'd127, 8'h00};
    do_reset();
    for (int i = 0; i < seq.size(); i++) begin
      tick(i < 3, seq[i]);
      if (dut_out !== model_outputs()) begin
        errors++;
        $display("FAIL single_note step%0d: got %h exp %h", i, dut_out, model_outputs());
      end
      checks++;
    end
    if ({voice_load, voice_active, steal, voice_note[6:0], voice_velocity[6:0]} !==
        {4'b0001, 4'b0001, 1'b0, 7'd60, 7'd127}) begin
      errors++;
      $display("FAIL single_note_fixed: load=%b act=%b steal=%b note=%0d vel=%0d exp 0001 0001 0 60 127",
               voice_load, voice_active, steal, voice_note[6:0], voice_velocity[6:0]);
    end
    checks++;
  endtask

  task automatic test_note_off();
    logic [7:0] seq[] = '{8'h90, 8'd60, 8'd127, 8'd64, 8'd127, 8'd67, 8'd127, 8'h00,
                          8'h80, 8'd64, 8'd0, 8'h00,
                          8'h90, 8'd67, 8'd0, 8'h00,
                          8'h80, 8'd72, 8'd0, 8'h00};
    do_reset();
    for (int i = 0; i < seq.size(); i++) begin
      tick(seq[i] != 8'h00 || (i % 4) != 3, seq[i]);
      if (dut_out !== model_outputs()) begin
        errors++;
        $display("FAIL note_off step%0d: got %h exp %h", i, dut_out, model_outputs());
      end
      checks++;
      if (i == 7 && voice_active !== 4'b0111) begin
        errors++;
        $display("FAIL running_status_active: got %b exp 0111", voice_active);
      end
      if (i == 11 && {voice_release, voice_active} !== {4'b0010, 4'b0101}) begin
        errors++;
        $display("FAIL off_80: rel=%b act=%b exp 0010 0101", voice_release, voice_active);
      end
      if (i == 15 && {voice_release, voice_active} !== {4'b0100, 4'b0001}) begin
        errors++;
        $display("FAIL off_vel0: rel=%b act=%b exp 0100 0001", voice_release, voice_active);
      end
      if (i == 19 && {voice_release, voice_load} !== 8'h00) begin
        errors++;
        $display("FAIL off_nohit: rel=%b load=%b exp 0000 0000", voice_release, voice_load);
      end
      if (i == 7 || i == 11 || i == 15 || i == 19) checks++;
    end
  endtask

  task automatic test_steal();
    logic [7:0] seq[] = '{8'h90, 8'd60, 8'd1, 8'd62, 8'd1, 8'd64, 8'd1, 8'd65, 8'd1,
                          8'd67, 8'd1, 8'h00, 8'd69, 8'd1, 8'h00};
    do_reset();
    for (int i = 0; i < seq.size(); i++) begin
      tick(seq[i] != 8'h00, seq[i]);
      if (dut_out !== model_outputs()) begin
        errors++;
        $display("FAIL steal step%0d: got %h exp %h", i, dut_out, model_outputs());
      end
      checks++;
    end
    // Last command: note 69 must take voice 1 (oldest after voice 0 was stolen)
    if ({voice_load, steal, voice_note[13:7]} !== {4'b0010, 1'b1, 7'd69}) begin
      errors++;
      $display("FAIL steal_second: load=%b steal=%b note1=%0d exp 0010 1 69",
               voice_load, steal, voice_note[13:7]);
    end
    checks++;
    if (voice_note[6:0] !== 7'd67) begin
      errors++;
      $display("FAIL steal_first: note0=%0d exp 67", voice_note[6:0]);
    end
    checks++;
  endtask

  task automatic test_retrigger_filter();
    logic [7:0] seq[] = '{8'h90, 8'd60, 8'd127, 8'h90, 8'd60, 8'hF8, 8'd50, 8'h00,
                          8'hB0, 8'd7, 8'd100, 8'd61, 8'd90, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < seq.size(); i++) begin
      tick(seq[i] != 8'h00, seq[i]);
      if (dut_out !== model_outputs()) begin
        errors++;
        $display("FAIL retrig_filter step%0d: got %h exp %h", i, dut_out, model_outputs());
      end
      checks++;
      if (i == 7 && {voice_load, voice_active, voice_velocity[6:0]} !== {4'b0001, 4'b0001, 7'd50}) begin
        errors++;
        $display("FAIL retrigger: load=%b act=%b vel0=%0d exp 0001 0001 50",
                 voice_load, voice_active, voice_velocity[6:0]);
      end
      if (i == 7) checks++;
      if (i >= 11 && (voice_load !== 4'b0000 || voice_active !== 4'b0001)) begin
        errors++;
        $display("FAIL ignore_cc step%0d: load=%b act=%b exp 0000 0001", i, voice_load, voice_active);
      end
      if (i >= 11) checks++;
    end
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    tick(1'b1, 8'h90); tick(1'b1, 8'd50); tick(1'b1, 8'd80);
    tick(1'b1, 8'h90); tick(1'b1, 8'd60);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    if (dut_out !== {OW{1'b0}}) begin
      errors++;
      $display("FAIL async_reset: got %h exp 0", dut_out);
    end
    checks++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(i == 0, 8'd127);
      if (dut_out !== {OW{1'b0}}) begin
        errors++;
        $display("FAIL reset_mid_msg step%0d: got %h exp 0", i, dut_out);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    logic rdy;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      r   = $urandom_range(0, 99);
      rdy = 1'b1;
      if (r < 10) begin
        rdy = 1'b0; b = 8'h00;
      end else if (r < 20) b = 8'h90 | 8'($urandom_range(0, 15));
      else if (r < 26) b = 8'h80 | 8'($urandom_range(0, 15));
      else if (r < 30) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 33) b = 8'($urandom_range(8'hA0, 8'hF7));
      else if ($urandom_range(0, 4) == 0) b = 8'h00;
      else b = 8'(60 + $urandom_range(0, 7));
      tick(rdy, b);
      if (dut_out !== model_outputs()) begin
        errors++;
        $display("FAIL random cycle%0d byte=%h: got %h exp %h", n, b, dut_out, model_outputs());
      end
      checks++;
    end
  endtask

  initial begin
    reset = 1'b1;
    new_byte_ready = 1'b0;
    new_byte = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_note();
    test_note_off();
    test_steal();
    test_retrigger_filter();
    test_reset_mid_message();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
